acc_alu_core: RTL and testbench

- Single-accumulator 8-bit datapath: instruction decoder, combinational ALU and an 8-bit accumulator register in one block.
- Each clock cycle it decodes one 8-bit instruction and computes ACC op IMM4.
- It optionally writes the result back into the accumulator.
- Sits at the top of the simple CPU. The board-level wrapper drives the instruction bus and presents the result, accumulator and status buses.

---
 rtl/acc_alu_core.sv | 99 +++++++++
 tb/tb_acc_alu_core.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_alu_core.sv
// -----------------------------------------------------------------------------
// acc_alu_core
//
// Single-accumulator 8-bit datapath. Each cycle the block decodes one
// instruction, computes ACC <op> IMM4 combinationally, and can write the
// result back into the accumulator on the next rising clock edge.
//
// Instruction word:
//   instr[7:5] opcode   000 ADD, 001 MUL, 010 AND, 011 OR, 100 NOT,
//                       101/110/111 PASS
//   instr[4]   write_en 1 = commit alu_result into ACC on the next edge
//   instr[3:0] imm      zero-extended to 8 bits as operand B
//
// Ports:
//   clk        in   1  system clock, rising-edge active
//   rst_n      in   1  asynchronous active-low reset, clears ACC
//   instr      in   8  instruction word (used combinationally)
//   alu_result out  8  combinational result for current instr and ACC
//   acc_out    out  8  registered accumulator contents
//   status     out  8  {opcode[2:0], write_en, 2'b00, ovf, zero}
//
// Flow control: there is no valid/ready handshake. Every cycle carries an
// instruction; an instruction with write_en=0 is a pure query of the ALU
// and leaves the accumulator untouched.
// -----------------------------------------------------------------------------
module acc_alu_core (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] instr,
  output logic [7:0] alu_result,
  output logic [7:0] acc_out,
  output logic [7:0] status
);

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_MUL  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_NOT  = 3'b100,
    OP_PASS = 3'b101
  } opcode_e;

  logic [7:0]  acc;
  logic [2:0]  opcode;
  logic        write_en;
  logic [7:0]  operand_b;
  logic [8:0]  sum;
  logic [11:0] product;
  logic        ovf;
  logic        zero;

  // Decode fields.
  assign opcode    = instr[7:5];
  assign write_en  = instr[4];
  assign operand_b = {4'b0000, instr[3:0]};

  // Widened arithmetic so carry / product overflow are visible.
  // 8-bit ACC times 4-bit immediate never needs more than 12 bits.
  assign sum     = {1'b0, acc} + {1'b0, operand_b};
  assign product = {4'b0000, acc} * {8'h00, instr[3:0]};

  // ALU: every opcode value maps to a defined result; 101..111 all pass ACC.
  always_comb begin
    alu_result = acc;
    ovf        = 1'b0;
    case (opcode)
      OP_ADD: begin
        alu_result = sum[7:0];
        ovf        = sum[8];
      end
      OP_MUL: begin
        alu_result = product[7:0];
        ovf        = |product[11:8];
      end
      OP_AND:  alu_result = acc & operand_b;
      OP_OR:   alu_result = acc | operand_b;
      OP_NOT:  alu_result = ~acc;
      default: alu_result = acc;
    endcase
  end

  assign zero = (alu_result == 8'h00);

  // Flags are not stored; status reflects only the current instr and ACC.
  assign status = {opcode, write_en, 2'b00, ovf, zero};

  // Accumulator register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= 8'h00;
    end else if (write_en) begin
      acc <= alu_result;
    end
  end

  assign acc_out = acc;

endmodule

// File: tb/tb_acc_alu_core.sv
// -----------------------------------------------------------------------------
// tb_acc_alu_core
//
// Self-checking bench for acc_alu_core. Directed scenarios use constants
// taken from the instruction-set rules; the randomized scenario uses a
// reference model written with plain integer arithmetic and a queue of
// expected accumulator values.
// -----------------------------------------------------------------------------
module tb_acc_alu_core;

  logic       clk;
  logic       rst_n;
  logic [7:0] instr;
  logic [7:0] alu_result;
  logic [7:0] acc_out;
  logic [7:0] status;

  int checks = 0;
  int errors = 0;

  logic [7:0] acc_model;
  logic [7:0] exp_q[$];

  acc_alu_core dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr      (instr),
    .alu_result (alu_result),
    .acc_out    (acc_out),
    .status     (status)
  );

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------------------------------------------------------------------
  // Reference model: returns {ovf, result} from plain integer arithmetic.
  // ---------------------------------------------------------------------------
  function automatic logic [8:0] ref_alu(input logic [7:0] a, input logic [7:0] ins);
    int av;
    int bv;
    int full;
    logic [7:0] res;
    logic ov;
    av = a;
    bv = ins[3:0];
    case (ins[7:5])
      3'd0:    full = av + bv;
      3'd1:    full = av * bv;
      3'd2:    full = av & bv;
      3'd3:    full = av | bv;
      3'd4:    full = 255 - av;
      default: full = av;
    endcase
    res = 8'(full % 256);
    ov  = (ins[7:5] <= 3'd1) && (full > 255);
    return {ov, res};
  endfunction

  function automatic logic [7:0] ref_status(input logic [7:0] a, input logic [7:0] ins);
    logic [8:0] r;
    r = ref_alu(a, ins);
    return {ins[7:5], ins[4], 2'b00, r[8], (r[7:0] == 8'h00)};
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // Apply instr at the falling edge, let the next rising edge commit it.
  task automatic drive_cycle(input logic [7:0] ins);
    @(negedge clk);
    instr = ins;
    @(posedge clk);
    if (rst_n && ins[4]) begin
      logic [8:0] r;
      r = ref_alu(acc_model, ins);
      acc_model = r[7:0];
    end
    #1;
  endtask

  // Reset between clock edges, then build the target value with ADD steps.
  task automatic load_acc(input logic [7:0] target);
    int rem;
    @(negedge clk);
    instr = 8'h00;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    acc_model = 8'h00;
    rem = target;
    while (rem > 0) begin
      int step;
      step = (rem > 15) ? 15 : rem;
      drive_cycle({3'b000, 1'b1, 4'(step)});
      rem = rem - step;
    end
  endtask

  // Present an instruction without crossing a rising edge.
  task automatic present(input logic [7:0] ins);
    @(negedge clk);
    instr = ins;
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    instr = 8'h00;
    acc_model = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (acc_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_init acc_out got %h exp 00", acc_out);
    end
    @(negedge clk);
    rst_n = 1'b1;

    load_acc(8'h5A);
    checks++;
    if (acc_out !== 8'h5A) begin
      errors++;
      $display("FAIL load_5a acc_out got %h exp 5a", acc_out);
    end

    // Assert reset between edges: ACC must clear without a clock edge.
    @(negedge clk);
    instr = 8'h00;
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (acc_out !== 8'h00) begin
      errors++;
      $display("FAIL async_reset acc_out got %h exp 00", acc_out);
    end
    checks++;
    if (alu_result !== 8'h00 || status !== 8'h01) begin
      errors++;
      $display("FAIL in_reset_comb result %h status %h exp 00 01", alu_result, status);
    end
    #1;
    rst_n = 1'b1;
    acc_model = 8'h00;

    drive_cycle(8'h00);
    checks++;
    if (alu_result !== 8'h00 || status[0] !== 1'b1 || acc_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_release result %h zero %b acc %h exp 00 1 00",
               alu_result, status[0], acc_out);
    end

    // Reset releasing in the cycle of a write: the first edge writes.
    @(negedge clk);
    rst_n = 1'b0;
    instr = 8'h11;
    #2;
    rst_n = 1'b1;
    acc_model = 8'h00;
    @(posedge clk);
    #1;
    checks++;
    if (acc_out !== 8'h01) begin
      errors++;
      $display("FAIL release_with_write acc_out got %h exp 01", acc_out);
    end
  endtask

  task automatic test_add();
    logic [7:0] exp_acc[3];
    exp_acc = '{8'h01, 8'h02, 8'h03};
    load_acc(8'h00);
    for (int i = 0; i < 3; i++) begin
      drive_cycle(8'h11);
      checks++;
      if (acc_out !== exp_acc[i]) begin
        errors++;
        $display("FAIL add_we_step%0d acc_out got %h exp %h", i, acc_out, exp_acc[i]);
      end
    end
    present(8'h01);
    checks++;
    if (alu_result !== 8'h04) begin
      errors++;
      $display("FAIL add_nowe result got %h exp 04", alu_result);
    end
    @(posedge clk);
    #1;
    checks++;
    if (acc_out !== 8'h03) begin
      errors++;
      $display("FAIL add_nowe_hold acc_out got %h exp 03", acc_out);
    end
  endtask

  task automatic test_carry();
    load_acc(8'hFE);
    present(8'h13);
    checks++;
    if (alu_result !== 8'h01 || status[1] !== 1'b1) begin
      errors++;
      $display("FAIL carry result %h ovf %b exp 01 1", alu_result, status[1]);
    end
    @(posedge clk);
    #1;
    checks++;
    if (acc_out !== 8'h01) begin
      errors++;
      $display("FAIL carry_commit acc_out got %h exp 01", acc_out);
    end
  endtask

  task automatic test_logic();
    logic [7:0] start_v[3];
    logic [7:0] ins_v[3];
    logic [7:0] exp_v[3];
    start_v = '{8'h06, 8'h09, 8'h08};
    ins_v   = '{8'h45, 8'h66, 8'h9E};
    exp_v   = '{8'h04, 8'h0F, 8'hF7};
    for (int i = 0; i < 3; i++) begin
      load_acc(start_v[i]);
      present(ins_v[i]);
      checks++;
      if (alu_result !== exp_v[i] || status[1] !== 1'b0) begin
        errors++;
        $display("FAIL logic_%0d result %h ovf %b exp %h 0", i, alu_result, status[1], exp_v[i]);
      end
    end
    // The NOT instruction above has write_en set.
    @(posedge clk);
    #1;
    checks++;
    if (acc_out !== 8'hF7) begin
      errors++;
      $display("FAIL not_commit acc_out got %h exp f7", acc_out);
    end
  endtask

  task automatic test_mul();
    load_acc(8'h02);
    present(8'h33);
    checks++;
    if (alu_result !== 8'h06 || status[1] !== 1'b0) begin
      errors++;
      $display("FAIL mul_2x3 result %h ovf %b exp 06 0", alu_result, status[1]);
    end
    load_acc(8'h00);
    present(8'h23);
    checks++;
    if (alu_result !== 8'h00 || status[0] !== 1'b1) begin
      errors++;
      $display("FAIL mul_0x3 result %h zero %b exp 00 1", alu_result, status[0]);
    end
    load_acc(8'h40);
    present(8'h28);
    checks++;
    if (alu_result !== 8'h00 || status[1] !== 1'b1 || status[0] !== 1'b1) begin
      errors++;
      $display("FAIL mul_40x8 result %h ovf %b zero %b exp 00 1 1",
               alu_result, status[1], status[0]);
    end
  endtask

  task automatic test_pass_async_reset();
    load_acc(8'h01);
    present(8'hF3);
    checks++;
    if (alu_result !== 8'h01 || status !== 8'hF0) begin
      errors++;
      $display("FAIL pass result %h status %h exp 01 f0", alu_result, status);
    end
    @(posedge clk);
    #1;
    checks++;
    if (acc_out !== 8'h01) begin
      errors++;
      $display("FAIL pass_hold acc_out got %h exp 01", acc_out);
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (acc_out !== 8'h00) begin
      errors++;
      $display("FAIL pulse_reset acc_out got %h exp 00", acc_out);
    end
    #1;
    rst_n = 1'b1;
    acc_model = 8'h00;
  endtask

  // Random instruction stream with occasional mid-cycle resets, checked
  // against the integer model and a queue of expected accumulator values.
  task automatic test_random();
    logic [7:0] ins;
    logic [8:0] r;
    for (int n = 0; n < 400; n++) begin
      ins = 8'($urandom_range(0, 255));
      @(negedge clk);
      instr = ins;
      if ($urandom_range(0, 39) == 0) begin
        #1;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        acc_model = 8'h00;
      end
      #1;
      r = ref_alu(acc_model, ins);
      checks++;
      if (alu_result !== r[7:0] || status !== ref_status(acc_model, ins)) begin
        errors++;
        $display("FAIL rand_comb acc %h instr %h result %h status %h exp %h %h",
                 acc_model, ins, alu_result, status, r[7:0], ref_status(acc_model, ins));
      end
      if (ins[4]) acc_model = r[7:0];
      exp_q.push_back(acc_model);
      @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rand_queue empty");
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (acc_out !== e) begin
          errors++;
          $display("FAIL rand_acc instr %h acc_out %h exp %h", ins, acc_out, e);
        end
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_add();
    test_carry();
    test_logic();
    test_mul();
    test_pass_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
